// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP adder: FSM state codes, flag layout,
// operand classification and width-parametrised special-value patterns.
package fp_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_PACK  = 3'd4;

    localparam logic [1:0] FLAG_ZERO      = 2'd0;
    localparam logic [1:0] FLAG_UNDERFLOW = 2'd1;
    localparam logic [1:0] FLAG_OVERFLOW  = 2'd2;
    localparam logic [1:0] FLAG_INVALID   = 2'd3;

    localparam logic [3:0] FL_ZERO      = 4'b0001 << FLAG_ZERO;
    localparam logic [3:0] FL_UNDERFLOW = 4'b0001 << FLAG_UNDERFLOW;
    localparam logic [3:0] FL_OVERFLOW  = 4'b0001 << FLAG_OVERFLOW;
    localparam logic [3:0] FL_INVALID   = 4'b0001 << FLAG_INVALID;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fpClass_e;

    // Widest word the pattern helpers can describe; callers slice to their width.
    localparam int FP_MAX_W = 128;

    // Denormals are treated as zero, so only the exponent decides zero-ness.
    function automatic fpClass_e classify(input logic expZero, input logic expOnes,
                                          input logic fracZero);
        if (expZero)
            return FP_ZERO;
        if (expOnes)
            return fracZero ? FP_INF : FP_NAN;
        return FP_NORMAL;
    endfunction

    function automatic logic [FP_MAX_W-1:0] infMagWide(input int expW, input int manW);
        logic [FP_MAX_W-1:0] one;
        one = {{(FP_MAX_W-1){1'b0}}, 1'b1};
        return ((one << expW) - one) << manW;
    endfunction

    function automatic logic [FP_MAX_W-1:0] qnanWide(input int expW, input int manW);
        logic [FP_MAX_W-1:0] one;
        one = {{(FP_MAX_W-1){1'b0}}, 1'b1};
        return infMagWide(expW, manW) | (one << (manW - 1));
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits a packed FP word into sign/exponent/fraction and classifies it.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic [EXP_W+MAN_W:0] word,
    output logic                 sign,
    output logic [EXP_W-1:0]     expField,
    output logic [MAN_W-1:0]     fracField,
    output fpClass_e             cls
);

    assign sign      = word[EXP_W+MAN_W];
    assign expField  = word[EXP_W+MAN_W-1:MAN_W];
    assign fracField = word[MAN_W-1:0];
    assign cls       = classify(expField == '0, &expField, fracField == '0);

endmodule

// File: rtl/fp_adder_seq.sv
// Multicycle FP adder/subtractor: IDLE -> ALIGN -> ADD -> NORM (iterative) -> PACK,
// truncating rounding, denormals flushed, start/done handshake.
module fp_adder_seq
    import fp_pkg::*;
#(
    parameter  int EXP_W = 11,
    parameter  int MAN_W = 52,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int                  M          = MAN_W + 2;  // carry + hidden + fraction
    localparam logic [FP_MAX_W-1:0] INF_WIDE   = infMagWide(EXP_W, MAN_W);
    localparam logic [FP_MAX_W-1:0] QNAN_WIDE  = qnanWide(EXP_W, MAN_W);
    localparam logic [W-2:0]        INF_MAG    = INF_WIDE[W-2:0];
    localparam logic [W-1:0]        QNAN       = QNAN_WIDE[W-1:0];
    localparam logic [EXP_W-1:0]    EXP_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [W-1:0]     opA, opB;
    logic [M-1:0]     sumReg, minReg;
    logic [EXP_W-1:0] expR;
    logic             resSign, effSub, special;
    logic [W-1:0]     packWord;
    logic [3:0]       pendFlags;

    logic             signA, signB;
    logic [EXP_W-1:0] expA, expB;
    logic [MAN_W-1:0] fracA, fracB;
    fpClass_e         clsA, clsB;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) unpackA (
        .word(opA), .sign(signA), .expField(expA), .fracField(fracA), .cls(clsA)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) unpackB (
        .word(opB), .sign(signB), .expField(expB), .fracField(fracB), .cls(clsB)
    );

    // Magnitude ordering and alignment of the smaller operand.
    logic             aIsMax;
    logic [EXP_W-1:0] expMax, expMin, expDiff;
    logic [MAN_W-1:0] fracMax, fracMin;
    logic             signMax;
    logic [M-1:0]     manMax, manMinAligned;

    assign aIsMax        = {expA, fracA} >= {expB, fracB};
    assign expMax        = aIsMax ? expA : expB;
    assign expMin        = aIsMax ? expB : expA;
    assign fracMax       = aIsMax ? fracA : fracB;
    assign fracMin       = aIsMax ? fracB : fracA;
    assign signMax       = aIsMax ? signA : signB;
    assign expDiff       = expMax - expMin;
    assign manMax        = {2'b01, fracMax};
    assign manMinAligned = {2'b01, fracMin} >> expDiff;

    logic         specHit;
    logic [W-1:0] specWord;
    logic [3:0]   specFlags;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        specHit   = 1'b1;
        specWord  = QNAN;
        specFlags = '0;
        if (clsA == FP_NAN || clsB == FP_NAN ||
            (clsA == FP_INF && clsB == FP_INF && signA != signB)) begin
            specFlags = FL_INVALID;
        end else if (clsA == FP_INF) begin
            specWord = opA;
        end else if (clsB == FP_INF) begin
            specWord = opB;
        end else if (clsA == FP_ZERO && clsB == FP_ZERO) begin
            specWord  = {signA & signB, {(W-1){1'b0}}};
            specFlags = FL_ZERO;
        end else if (clsA == FP_ZERO) begin
            specWord = opB;
        end else if (clsB == FP_ZERO) begin
            specWord = opA;
        end else begin
            specHit = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

    // NOTE: all state, including the operand and datapath registers, is cleared by reset so
    // an aborted operation leaves nothing behind; sequential updates are non-blocking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            opA       <= '0;
            opB       <= '0;
            sumReg    <= '0;
            minReg    <= '0;
            expR      <= '0;
            resSign   <= 1'b0;
            effSub    <= 1'b0;
            special   <= 1'b0;
            packWord  <= '0;
            pendFlags <= '0;
            done      <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is folded into the captured sign of B.
                        opA   <= src_a;
                        opB   <= {src_b[W-1] ^ op_sub, src_b[W-2:0]};
                        state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    resSign   <= signMax;
                    expR      <= expMax;
                    sumReg    <= manMax;
                    minReg    <= manMinAligned;
                    effSub    <= signA ^ signB;
                    special   <= specHit;
                    packWord  <= specWord;
                    pendFlags <= specFlags;
                    state     <= specHit ? ST_PACK : ST_ADD;
                end
                ST_ADD: begin
                    sumReg <= effSub ? (sumReg - minReg) : (sumReg + minReg);
                    state  <= ST_NORM;
                end
                ST_NORM: begin
                    if (sumReg == '0) begin
                        special   <= 1'b1;
                        packWord  <= '0;
                        pendFlags <= FL_ZERO;
                        state     <= ST_PACK;
                    end else if (sumReg[M-1]) begin
                        sumReg <= sumReg >> 1;
                        expR   <= expR + EXP_ONE;
                        state  <= ST_PACK;
                    end else if (!sumReg[MAN_W]) begin
                        if (expR == EXP_ONE) begin
                            special   <= 1'b1;
                            packWord  <= {resSign, {(W-1){1'b0}}};
                            pendFlags <= FL_UNDERFLOW | FL_ZERO;
                            state     <= ST_PACK;
                        end else begin
                            sumReg <= sumReg << 1;
                            expR   <= expR - EXP_ONE;
                        end
                    end else begin
                        state <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                    if (special) begin
                        result <= packWord;
                        flags  <= pendFlags;
                    end else if (&expR) begin
                        result <= {resSign, INF_MAG};
                        flags  <= FL_OVERFLOW;
                    end else begin
                        result <= {resSign, expR, sumReg[MAN_W-1:0]};
                        flags  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_adder_seq.md
Name: fp_adder_seq

Overview:
Parametrised multicycle IEEE-754-style floating-point adder/subtractor for the datapath's FP unit. It supports configurable exponent and mantissa width (double by default, single by parameter), signed operands, an add/sub mode, and special values. A start/done handshake makes it stall-compatible with the multicycle controller. Operation runs through a small FSM with iterative left-normalisation.

Parameters:
EXP_W, 11, exponent field width
MAN_W, 52, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request; sampled only in IDLE
op_sub  in  1  1: result = src_a - src_b; 0: src_a + src_b
src_a  in  W  operand A, {sign, exp, frac}
src_b  in  W  operand B
busy  out  1  high while an operation is in flight (ALIGN..PACK)
done  out  1  one-cycle pulse; result/flags valid from this cycle until next done
result  out  W  packed sum
flags  out  4  {invalid, overflow, underflow, zero}

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; busy=0, done=0, result=0, flags=0; internal registers cleared. Reset mid-operation aborts and produces no done.
- States: IDLE, ALIGN, ADD, NORM, PACK.
- IDLE: when start=1, capture src_a and src_b, with B sign XOR op_sub. -> ALIGN. start is ignored in every other state. start in the cycle done=1 is accepted, because state is IDLE.
- Operand classes:
  - exp==0: zero. Denormals are flushed; fraction ignored.
  - exp==all-ones: Inf if frac==0, else NaN.
- ALIGN:
  - Special cases go directly to PACK:
    - any NaN, or Inf plus opposite-sign Inf: qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
    - otherwise any Inf: that Inf.
    - both zero: sign = AND of signs.
    - one zero: the other operand unchanged.
  - Otherwise: mantissas = {1, frac} in MAN_W+2 bits with a carry bit.
  - Order operands by magnitude (exp, then mantissa); the larger is max.
  - diff = exp_max - exp_min. min mantissa >>= diff, truncating; diff > MAN_W+1 gives 0.
  - Result sign = max sign; exp_r = exp_max. -> ADD.
- ADD: same signs: sum = max + min; otherwise sum = max - min, which is never negative. -> NORM.
- NORM, evaluated once per cycle:
  - sum==0: exact cancellation, result +0, zero=1, -> PACK.
  - Carry bit set: sum >>= 1, exp_r += 1, -> PACK.
  - Hidden bit clear: sum <<= 1, exp_r -= 1, stay in NORM. If exp_r would reach 0, flush to signed zero with underflow=1, zero=1, -> PACK.
  - Otherwise -> PACK.
- PACK:
  - If exp_r == all-ones: Inf, overflow=1.
  - Otherwise result = {sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]}.
  - Register result and flags, set done=1, -> IDLE.
- Rounding: truncation only, toward zero of the aligned magnitude.
- Latency: start sampled at edge 0. done rises after edge 4+k, where k = number of NORM left shifts (0 <= k <= MAN_W). Special cases: done after edge 2. busy is 1 from edge 0 until the edge that raises done.
- Throughput: one operation in flight; no queuing.

Decomposition:
- Shared package fp_pkg: state enum, flag bit indices, a function classifying operands (zero/inf/nan/normal), and the qNaN/Inf pattern constants, all parametrised by EXP_W/MAN_W.
- One natural sub-module: fp_unpack, a combinational field split plus classification, instantiated per operand.
- Shifter, adder and FSM remain inside fp_adder_seq.

Test Plan:
- Double precision, 1.0+2.0: 0x3FF0000000000000 and 0x4000000000000000, op_sub=0 -> result 0x4008000000000000, flags=0, done after edge 4, busy high edges 0..4.
- 3.0-2.0: 0x4008000000000000 and 0x4000000000000000, op_sub=1 -> result 0x3FF0000000000000 with k=1, done after edge 5. 1.0-1.0 -> 0x0000000000000000, zero=1.
- Overflow: 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF -> 0x7FF0000000000000, overflow=1. +Inf (0x7FF0...) + -Inf (0xFFF0...) -> 0x7FF8000000000000, invalid=1, done after edge 2.
- EXP_W=8, MAN_W=23, 1.5+1.5: 0x3FC00000 + 0x3FC00000 -> 0x40400000. 1.0 + 2^-30: 0x3F800000 + 0x30800000 -> 0x3F800000, alignment truncates the smaller operand to 0.
- Handshake: pulse start during busy with different operands -> ignored, and the first result is unchanged. start in the done cycle -> second op accepted, back-to-back done pulses spaced 5 cycles.
- Drive reset low during NORM of a long-cancellation op -> busy=0, done=0, result=0 immediately without waiting for a clock edge. Next start completes normally.
